// File: rtl/sram_port_arb_pkg.sv
// Shared types for the SRAM port arbiter.
// Index type wide enough for up to 16 requesters, plus the response-pipeline entry.
package sram_port_arb_pkg;

  localparam int MaxReq   = 16;
  localparam int IdxWidth = $clog2(MaxReq);

  typedef logic [IdxWidth-1:0] idx_t;

  typedef struct packed {
    logic valid;
    idx_t idx;
    logic we;
  } resp_t;

endpackage

// File: rtl/sram_port_arb_rr.sv
// Round-robin winner search, purely combinational.
// Ports: req_i (requests), last_i (last winner) -> gnt_o (one-hot), idx_o, valid_o.
module sram_port_arb_rr
  import sram_port_arb_pkg::*;
#(
  parameter int NumReq = 4
) (
  input  logic [NumReq-1:0] req_i,
  input  idx_t              last_i,
  output logic [NumReq-1:0] gnt_o,
  output idx_t              idx_o,
  output logic              valid_o
);

  // Two passes: indices above last first, then wrap to 0..last.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = 0; k < NumReq; k++) begin
      if (!valid_o && req_i[k] && (k > int'(last_i))) begin
        valid_o  = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = idx_t'(k);
      end
    end
    for (int k = 0; k < NumReq; k++) begin
      if (!valid_o && req_i[k] && (k <= int'(last_i))) begin
        valid_o  = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = idx_t'(k);
      end
    end
  end

endmodule

// File: rtl/sram_port_arb.sv
// Round-robin arbiter sharing one SRAM port among NumReq requesters.
// Ports: clk_i, rst_ni, per-requester req/we/addr/wdata/be in, gnt_o/rvalid_o/rdata_o out,
//        sram_* drive the SRAM port, sram_rdata_i returns read data after Latency cycles.
module sram_port_arb
  import sram_port_arb_pkg::*;
#(
  parameter  int NumReq    = 4,
  parameter  int NumWords  = 1024,
  parameter  int DataWidth = 128,
  parameter  int ByteWidth = 8,
  parameter  int Latency   = 1,
  localparam int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumReq-1:0]                   req_i,
  input  logic [NumReq-1:0]                   we_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]    addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0]    wdata_i,
  input  logic [NumReq-1:0][BeWidth-1:0]      be_i,
  output logic [NumReq-1:0]                   gnt_o,
  output logic [NumReq-1:0]                   rvalid_o,
  output logic [DataWidth-1:0]                rdata_o,
  output logic                                sram_req_o,
  output logic                                sram_we_o,
  output logic [AddrWidth-1:0]                sram_addr_o,
  output logic [DataWidth-1:0]                sram_wdata_o,
  output logic [BeWidth-1:0]                  sram_be_o,
  input  logic [DataWidth-1:0]                sram_rdata_i
);

  localparam int SelWidth = $clog2(NumReq);

  idx_t                r_last;
  resp_t               r_pipe [Latency];
  logic [NumReq-1:0]   w_gnt;
  idx_t                w_idx;
  logic                w_valid;
  logic [SelWidth-1:0] w_sel;
  resp_t               w_head;

  sram_port_arb_rr #(
    .NumReq (NumReq)
  ) u_rr (
    .req_i   (req_i),
    .last_i  (r_last),
    .gnt_o   (w_gnt),
    .idx_o   (w_idx),
    .valid_o (w_valid)
  );

  assign gnt_o = w_gnt;
  assign w_sel = w_idx[SelWidth-1:0];

  always_comb begin
    sram_req_o   = |req_i;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    if (w_valid) begin
      sram_we_o    = we_i[w_sel];
      sram_addr_o  = addr_i[w_sel];
      sram_wdata_o = wdata_i[w_sel];
      sram_be_o    = be_i[w_sel];
    end
  end

  // Each grant enters the pipe and pops out exactly Latency cycles later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last <= idx_t'(NumReq - 1);
      for (int i = 0; i < Latency; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      if (w_valid) begin
        r_last <= w_idx;
      end
      r_pipe[0] <= '{valid: w_valid, idx: w_idx, we: sram_we_o};
      for (int i = 1; i < Latency; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign w_head = r_pipe[Latency-1];

  always_comb begin
    rvalid_o = '0;
    if (w_head.valid) begin
      rvalid_o[w_head.idx[SelWidth-1:0]] = 1'b1;
    end
  end

  assign rdata_o = (w_head.valid && !w_head.we) ? sram_rdata_i : '0;

endmodule

// File: tb/tb_sram_port_arb.sv
// Bench for sram_port_arb: two instances (Latency 1 and 3) share stimulus,
// each with its own SRAM model, checked every cycle against a grant-history model.
module tb_sram_port_arb;

  localparam int N  = 4;
  localparam int NW = 16;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int BW = 4;
  localparam int SW = 2;
  localparam int LA = 1;
  localparam int LB = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0]         req, we;
  logic [N-1:0][AW-1:0] addr;
  logic [N-1:0][DW-1:0] wdata;
  logic [N-1:0][BW-1:0] be;

  logic [N-1:0]  gnt_a, rvalid_a, gnt_b, rvalid_b;
  logic [DW-1:0] rdata_a, rdata_b, swdata_a, swdata_b, srdata_a, srdata_b;
  logic          sreq_a, swe_a, sreq_b, swe_b;
  logic [AW-1:0] saddr_a, saddr_b;
  logic [BW-1:0] sbe_a, sbe_b;

  always #5 clk = ~clk;

  sram_port_arb #(
    .NumReq(N), .NumWords(NW), .DataWidth(DW), .ByteWidth(8), .Latency(LA)
  ) u_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt_a), .rvalid_o(rvalid_a),
    .rdata_o(rdata_a), .sram_req_o(sreq_a), .sram_we_o(swe_a),
    .sram_addr_o(saddr_a), .sram_wdata_o(swdata_a), .sram_be_o(sbe_a),
    .sram_rdata_i(srdata_a)
  );

  sram_port_arb #(
    .NumReq(N), .NumWords(NW), .DataWidth(DW), .ByteWidth(8), .Latency(LB)
  ) u_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt_b), .rvalid_o(rvalid_b),
    .rdata_o(rdata_b), .sram_req_o(sreq_b), .sram_we_o(swe_b),
    .sram_addr_o(saddr_b), .sram_wdata_o(swdata_b), .sram_be_o(sbe_b),
    .sram_rdata_i(srdata_b)
  );

  function automatic logic [DW-1:0] init_word(input int a);
    return 32'h1000_0000 + 32'(a);
  endfunction

  // SRAM models
  logic [DW-1:0] mem_a [NW];
  logic [DW-1:0] mem_b [NW];
  logic [DW-1:0] rdq_a [LA];
  logic [DW-1:0] rdq_b [LB];
  bit ld_a = 1'b0;
  bit ld_b = 1'b0;

  always @(posedge clk) begin
    if (!ld_a) begin
      for (int a = 0; a < NW; a++) mem_a[a] <= init_word(a);
      ld_a <= 1'b1;
    end else if (sreq_a && swe_a) begin
      for (int j = 0; j < BW; j++)
        if (sbe_a[j]) mem_a[saddr_a][j*8 +: 8] <= swdata_a[j*8 +: 8];
    end
    rdq_a[0] <= mem_a[saddr_a];
  end
  assign srdata_a = rdq_a[LA-1];

  always @(posedge clk) begin
    if (!ld_b) begin
      for (int a = 0; a < NW; a++) mem_b[a] <= init_word(a);
      ld_b <= 1'b1;
    end else if (sreq_b && swe_b) begin
      for (int j = 0; j < BW; j++)
        if (sbe_b[j]) mem_b[saddr_b][j*8 +: 8] <= swdata_b[j*8 +: 8];
    end
    rdq_b[0] <= mem_b[saddr_b];
    for (int i = 1; i < LB; i++) rdq_b[i] <= rdq_b[i-1];
  end
  assign srdata_b = rdq_b[LB-1];

  // Scoreboard state
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last;
  logic [DW-1:0] gmem [NW];
  bit            hv   [8];
  int            hcyc [8];
  int            hidx [8];
  bit            hwe  [8];
  logic [DW-1:0] hdat [8];
  int wait_c [N];
  int gcount = 0;
  int rcount_a = 0;
  int rcount_b = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic resp_chk(input string nm, input int lat,
                          input logic [N-1:0] rv, input logic [DW-1:0] rd);
    int s;
    logic [N-1:0]  erv;
    logic [DW-1:0] erd;
    erv = '0;
    erd = '0;
    if (cyc >= lat) begin
      s = (cyc - lat) % 8;
      if (hv[s] && hcyc[s] == cyc - lat) begin
        erv = N'(1) << hidx[s];
        erd = hwe[s] ? '0 : hdat[s];
      end
    end
    chk({nm, "_rvalid"}, 64'(rv), 64'(erv));
    chk({nm, "_rdata"}, 64'(rd), 64'(erd));
  endtask

  // Compare process: runs once per cycle, mid-low-phase.
  always @(negedge clk) begin
    int w, mx, s;
    logic [N-1:0]    eg;
    logic [41:0]     eb;
    logic [SW-1:0]   wi;
    #2;
    if (cyc == 0) begin
      for (int a = 0; a < NW; a++) gmem[a] = init_word(a);
      for (int i = 0; i < 8; i++) hv[i] = 1'b0;
      last = N - 1;
    end
    if (!rst_n) begin
      last = N - 1;
      for (int i = 0; i < 8; i++) hv[i] = 1'b0;
      for (int k = 0; k < N; k++) wait_c[k] = 0;
      chk("rst_rvalid_a", 64'(rvalid_a), 64'd0);
      chk("rst_rdata_a", 64'(rdata_a), 64'd0);
      chk("rst_rvalid_b", 64'(rvalid_b), 64'd0);
      chk("rst_rdata_b", 64'(rdata_b), 64'd0);
    end else begin
      w = -1;
      for (int o = 1; o <= N; o++)
        if (w < 0 && req[SW'((last + o) % N)]) w = (last + o) % N;
      eg = '0;
      eb = '0;
      wi = '0;
      if (w >= 0) begin
        wi = SW'(w);
        eg = N'(1) << w;
        eb = {1'b1, we[wi], addr[wi], be[wi], wdata[wi]};
      end else if (req != '0) begin
        eb = 42'd1 << 41;
      end
      chk("gnt_a", 64'(gnt_a), 64'(eg));
      chk("gnt_b", 64'(gnt_b), 64'(eg));
      chk("gnt_onehot", 64'($countones(gnt_a) <= 1), 64'd1);
      chk("sram_a", 64'({sreq_a, swe_a, saddr_a, sbe_a, swdata_a}), 64'(eb));
      chk("sram_b", 64'({sreq_b, swe_b, saddr_b, sbe_b, swdata_b}), 64'(eb));
      mx = 0;
      for (int k = 0; k < N; k++) begin
        if (req[SW'(k)] && !gnt_a[SW'(k)]) wait_c[k]++;
        else wait_c[k] = 0;
        if (wait_c[k] > mx) mx = wait_c[k];
      end
      chk("wait_bound", 64'(mx <= N - 1), 64'd1);
      resp_chk("a", LA, rvalid_a, rdata_a);
      resp_chk("b", LB, rvalid_b, rdata_b);
      if (rvalid_a != '0) rcount_a++;
      if (rvalid_b != '0) rcount_b++;
      s = cyc % 8;
      hv[s]   = (w >= 0);
      hcyc[s] = cyc;
      hidx[s] = w;
      hwe[s]  = (w >= 0) ? we[wi] : 1'b0;
      hdat[s] = gmem[addr[wi]];
      if (w >= 0) begin
        if (we[wi])
          for (int j = 0; j < BW; j++)
            if (be[wi][j]) gmem[addr[wi]][j*8 +: 8] = wdata[wi][j*8 +: 8];
        gcount++;
        last = w;
      end
    end
    cyc++;
  end

  task automatic step(input logic [N-1:0] r, input logic w,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    req = r;
    for (int k = 0; k < N; k++) begin
      if (r[k]) begin
        we[k] = w; addr[k] = a; wdata[k] = d; be[k] = '1;
      end else begin
        we[k] = ~w; addr[k] = ~a; wdata[k] = ~d; be[k] = '0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0; be = '0;
    repeat (3) @(negedge clk);
    #3;
    chk("lit_reset_rvalid_a", 64'(rvalid_a), 64'd0);
    chk("lit_reset_rdata_b", 64'(rdata_b), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First read after reset goes to requester 0
    step(4'b0001, 1'b0, 4'd5, 32'h0);
    #3;
    chk("lit_first_gnt", 64'(gnt_a), 64'h1);
    chk("lit_first_addr", 64'(saddr_a), 64'h5);
    step(4'b0000, 1'b0, 4'd0, 32'h0);
    #3;
    chk("lit_first_rvalid", 64'(rvalid_a), 64'h1);
    chk("lit_first_rdata", 64'(rdata_a), 64'h1000_0005);

    // Write by requester 2, then read back by requester 1
    step(4'b0100, 1'b1, 4'd3, 32'hAAAA_AAAA);
    #3;
    chk("lit_wr_gnt", 64'(gnt_a), 64'h4);
    step(4'b0010, 1'b0, 4'd3, 32'h0);
    #3;
    chk("lit_wr_rvalid", 64'(rvalid_a), 64'h4);
    chk("lit_wr_rdata", 64'(rdata_a), 64'h0);
    step(4'b0000, 1'b0, 4'd0, 32'h0);
    #3;
    chk("lit_rd_rvalid", 64'(rvalid_a), 64'h2);
    chk("lit_rd_rdata", 64'(rdata_a), 64'hAAAA_AAAA);

    // All four requesting: strict rotation
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, 1'b0, 4'(i), 32'h0);
      #3;
      chk("lit_rot_gnt", 64'(gnt_a), 64'(4'b0001 << (i % 4)));
      if (i > 0)
        chk("lit_rot_rvalid", 64'(rvalid_a), 64'(4'b0001 << ((i - 1) % 4)));
    end

    // Alternating pairs, Latency-3 responses
    do_reset();
    for (int j = 0; j < 8; j++) begin
      if (j < 4) step((j % 2 == 0) ? 4'b0101 : 4'b1010, 1'b0, 4'(j), 32'h0);
      else step(4'b0000, 1'b0, 4'd0, 32'h0);
      #3;
      if (j < 4) chk("lit_alt_gnt", 64'(gnt_a), 64'(4'b0001 << j));
      if (j >= 3 && j < 7)
        chk("lit_alt_rvalid_b", 64'(rvalid_b), 64'(4'b0001 << (j - 3)));
    end

    // Reset while a read is in flight
    step(4'b0001, 1'b0, 4'd7, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    #3;
    chk("lit_drop_a", 64'(rvalid_a), 64'h0);
    chk("lit_drop_b", 64'(rvalid_b), 64'h0);
    @(negedge clk);
    #3;
    chk("lit_drop_b2", 64'(rvalid_b), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1000, 1'b0, 4'd9, 32'h0);
    #3;
    chk("lit_post_rst_gnt", 64'(gnt_a), 64'h8);
    step(4'b0000, 1'b0, 4'd0, 32'h0);
    #3;
    chk("lit_post_rst_rvalid", 64'(rvalid_a), 64'h8);
    chk("lit_post_rst_rdata", 64'(rdata_a), 64'h1000_0009);
    repeat (4) step(4'b0000, 1'b0, 4'd0, 32'h0);

    // Random traffic
    gcount = 0;
    rcount_a = 0;
    rcount_b = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      req = 4'($urandom);
      for (int k = 0; k < N; k++) begin
        we[k]    = 1'($urandom);
        addr[k]  = 4'($urandom);
        wdata[k] = $urandom;
        be[k]    = 4'($urandom);
      end
    end
    repeat (6) step(4'b0000, 1'b0, 4'd0, 32'h0);
    #3;
    chk("resp_count_a", 64'(rcount_a), 64'(gcount));
    chk("resp_count_b", 64'(rcount_b), 64'(gcount));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_port_arb.md
SRAM_PORT_ARB -- requirements
Module: sram_port_arb

Interface
REQ-001 SHALL have parameter NumReq, default 4, meaning number of requesters sharing one SRAM port (2..16).
REQ-002 SHALL have parameter NumWords, default 1024, meaning SRAM depth; AddrWidth = clog2(NumWords), minimum 1.
REQ-003 SHALL have parameter DataWidth, default 128, meaning data width.
REQ-004 SHALL have parameter ByteWidth, default 8, meaning byte width; BeWidth = ceil(DataWidth/ByteWidth).
REQ-005 SHALL have parameter Latency, default 1, meaning SRAM read latency in cycles (1..4).
REQ-006 SHALL have port clk_i  in  1  the single clock.
REQ-007 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port req_i  in  NumReq  per-requester request.
REQ-009 SHALL have port we_i  in  NumReq  per-requester write enable.
REQ-010 SHALL have port addr_i  in  NumReq x AddrWidth  per-requester address.
REQ-011 SHALL have port wdata_i  in  NumReq x DataWidth  per-requester write data.
REQ-012 SHALL have port be_i  in  NumReq x BeWidth  per-requester byte enable.
REQ-013 SHALL have port gnt_o  out  NumReq  grant, one-hot or zero.
REQ-014 SHALL have port rvalid_o  out  NumReq  response valid.
REQ-015 SHALL have port rdata_o  out  DataWidth  response data, shared by all requesters.
REQ-016 SHALL have ports sram_req_o, sram_we_o (out 1), sram_addr_o (out AddrWidth), sram_wdata_o (out DataWidth), sram_be_o (out BeWidth) driving one SRAM port.
REQ-017 SHALL have port sram_rdata_i  in  DataWidth  SRAM read data, valid Latency cycles after a read request.

Function
REQ-018 SHALL grant combinationally in the request cycle: gnt_o[k]=1 only if req_i[k]=1 and k is the round-robin winner.
REQ-019 SHALL select the winner as the first requesting index searching upward from (last_granted+1) mod NumReq, wrapping.
REQ-020 SHALL update last_granted to the winner on every cycle with a grant; no update when no req_i is set.
REQ-021 SHALL drive sram_req_o = OR(req_i); SRAM address/we/wdata/be SHALL be muxed from the winner; all SRAM outputs zero when no request.
REQ-022 SHALL assert rvalid_o[k] exactly Latency cycles after gnt_o[k], for reads and writes alike (one response per grant).
REQ-023 SHALL track responses in a Latency-deep shift register of {valid, winner index, we}, advancing every cycle.
REQ-024 SHALL drive rdata_o = sram_rdata_i when the response is a read, zero when a write or no response.
REQ-025 SHALL accept a new grant every cycle; back-to-back grants to the same requester allowed if it is the only requester.
REQ-026 SHALL keep a requester with req_i held waiting at most NumReq-1 cycles (no starvation).
REQ-027 SHALL ignore we_i/addr_i/wdata_i/be_i of non-granted requesters.

Reset
REQ-028 SHALL reset last_granted to NumReq-1 so requester 0 wins first.
REQ-029 SHALL clear all response-pipeline valid bits on reset; rvalid_o and rdata_o SHALL be zero during and after reset until a new grant matures.
REQ-030 SHALL drop in-flight responses when reset asserts mid-operation; no rvalid_o for grants issued before reset.

Structure
REQ-031 SHALL place the index type (clog2(NumReq) bits) and response-entry struct {valid, idx, we} in package sram_port_arb_pkg.
REQ-032 SHALL implement the winner search as sub-module sram_port_arb_rr (combinational: req vector + last pointer -> one-hot grant, index).
REQ-033 SHALL contain no storage besides last_granted and the response shift register.

Verification
REQ-034 SHALL cover: reset release, req_i=0001, we=0, addr=5 -> gnt_o=0001 same cycle, sram_addr_o=5, rvalid_o=0001 after 1 cycle with stored word.
REQ-035 SHALL cover: req_i=1111 held 8 cycles -> grants 0001,0010,0100,1000,0001,... each cycle, rvalid one cycle later per grant.
REQ-036 SHALL cover: requester 2 writes 0xAA..AA be=all-ones addr 3, then requester 1 reads addr 3 -> rdata_o=0xAA..AA with rvalid_o=0010, write response rdata_o=0.
REQ-037 SHALL cover: Latency=3, alternating req_i=0101/1010 -> each rvalid_o bit exactly 3 cycles after its gnt_o bit.
REQ-038 SHALL cover: rst_ni asserted one cycle after a read grant -> no rvalid_o; after release req_i=1000 -> gnt_o=1000 with requester 0 idle.
REQ-039 SHALL cover: random req_i for 10k cycles -> one-hot-or-zero gnt_o, waiting time never above NumReq-1, response count equals grant count.
